// File: rtl/dwc_pkg.sv
// Shared types for the command-path upsizer: pack FSM states and the default-width beat record.
// Default widths can be overridden at build time through DWC_PKG_IN_W / DWC_PKG_OUT_W.
`ifndef DWC_PKG_IN_W
`define DWC_PKG_IN_W 32
`endif
`ifndef DWC_PKG_OUT_W
`define DWC_PKG_OUT_W 128
`endif

package dwc_pkg;

    localparam int DWC_IN_W  = `DWC_PKG_IN_W;
    localparam int DWC_OUT_W = `DWC_PKG_OUT_W;
    localparam int DWC_RATIO = DWC_OUT_W / DWC_IN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        FLUSH = 2'b10
    } pack_state_e;

    typedef struct packed {
        logic [DWC_OUT_W-1:0] data;
        logic [DWC_RATIO-1:0] keep;
        logic                 last;
    } dwc_beat_t;

    // Counter/pointer width that stays legal (>=1 bit) when only one value is needed.
    function automatic int dwc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dwc_beat_fifo.sv
// Synchronous FIFO of packed beats, DEPTH entries; an entry is visible on pop_dat the cycle after push.
// Backpressure: push is dropped when full (callers gate on full); full/empty/fill come straight from flops.
module dwc_beat_fifo
    import dwc_pkg::*;
#(
    parameter int W      = 8,
    parameter int DEPTH  = 2,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [W-1:0]      push_dat,
    input  logic              pop_rdy,
    output logic [W-1:0]      pop_dat,
    output logic              full,
    output logic              empty,
    output logic [FILL_W-1:0] fill
);
    localparam int               PTR_W   = dwc_cnt_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

    logic [W-1:0]      mem_q [DEPTH];
    logic [W-1:0]      mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full    = (cnt_q == FILL_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign fill    = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_rdy && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + FILL_W'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - FILL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dwc_cmd_upsizer.sv
// Packs IN_W command words into OUT_W beats with keep/last; optional idle flush under `define DWC_CMD_TIMEOUT_EN.
// Latency: closing word to m_valid is 1 cycle; s_ready is registered and drops while the beat buffer is full.
module dwc_cmd_upsizer
    import dwc_pkg::*;
#(
    parameter int IN_W      = DWC_IN_W,
    parameter int OUT_W     = DWC_OUT_W,
    parameter int RATIO     = OUT_W / IN_W,
    parameter int OUT_DEPTH = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [IN_W-1:0]                s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [OUT_W-1:0]               m_data,
    output logic [RATIO-1:0]               m_keep,
    output logic                           m_last,
    output logic [1:0]                     state,
    output logic [$clog2(OUT_DEPTH+1)-1:0] fill
);
    localparam int               CNT_W    = dwc_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } beat_t;

    if (OUT_W % IN_W != 0) begin : g_bad_width
        $error("dwc_cmd_upsizer: OUT_W must be a multiple of IN_W");
    end
    if (RATIO < 1 || RATIO * IN_W != OUT_W) begin : g_bad_ratio
        $error("dwc_cmd_upsizer: RATIO is derived as OUT_W/IN_W and must not be overridden");
    end
    if (OUT_DEPTH < 2) begin : g_bad_depth
        $error("dwc_cmd_upsizer: OUT_DEPTH must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dwc_cmd_upsizer: TIMEOUT must be at least 1");
    end

    pack_state_e      state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [OUT_W-1:0] pack_q, pack_d, pack_nxt;
    logic             rdy_en_q, rdy_en_d;
    logic [CNT_W:0]   n_words;
    logic             acc, closes, tmo, push;
    logic             buf_full, buf_empty;
    beat_t            beat_in, beat_out;

    // Only registered terms here, so m_ready never reaches s_ready combinationally.
    assign s_ready = rdy_en_q && !buf_full && (state_q != FLUSH);
    assign acc     = s_valid && s_ready;
    assign closes  = acc && (s_last || (word_cnt_q == LAST_CNT));
    assign push    = closes || ((tmo || state_q == FLUSH) && !buf_full);

`ifdef DWC_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] idle_q, idle_d;

    // Fires on the TIMEOUT-th consecutive idle cycle in FILL; an accept always wins.
    always_comb begin
        tmo    = (state_q == FILL) && !acc && (idle_q == TMO_W'(TIMEOUT - 1));
        idle_d = '0;
        if (state_q == FILL && !acc && !tmo) begin
            idle_d = idle_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        rdy_en_d = 1'b1;
        pack_nxt = pack_q;
        if (acc) begin
            pack_nxt[word_cnt_q * IN_W +: IN_W] = s_data;
        end
        n_words = {1'b0, word_cnt_q} + {{CNT_W{1'b0}}, acc};

        beat_in      = '0;
        beat_in.data = pack_nxt;
        beat_in.last = acc && s_last;
        for (int i = 0; i < RATIO; i++) begin
            beat_in.keep[i] = ((CNT_W + 1)'(i) < n_words);
        end

        // Clearing the pack register on every push keeps unused words of the next beat zero.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_nxt;
        if (push) begin
            pack_d     = '0;
            word_cnt_d = '0;
            state_d    = IDLE;
        end else if (acc) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            state_d    = FILL;
        end else if (tmo) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            pack_q     <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    dwc_beat_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (OUT_DEPTH)
    ) u_beat_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (beat_in),
        .pop_rdy  (m_ready),
        .pop_dat  (beat_out),
        .full     (buf_full),
        .empty    (buf_empty),
        .fill     (fill)
    );

    assign m_valid = !buf_empty;
    assign m_data  = m_valid ? beat_out.data : '0;
    assign m_keep  = m_valid ? beat_out.keep : '0;
    assign m_last  = m_valid && beat_out.last;
    assign state   = state_q;

endmodule

// File: tb/tb_dwc_cmd_upsizer.sv
// Bench for dwc_cmd_upsizer: 4:1 instance plus a 1:1 instance, checked against a word-list model every cycle.
module tb_dwc_cmd_upsizer;
    import dwc_pkg::*;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [31:0]  s_data = '0;
    logic         m_valid, m_last, m_ready = 1'b1;
    logic [127:0] m_data;
    logic [3:0]   m_keep;
    logic [1:0]   state, fill;

    logic         s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
    logic [31:0]  s1_data = '0;
    logic         m1_valid, m1_last, m1_ready = 1'b1;
    logic [31:0]  m1_data;
    logic [0:0]   m1_keep;
    logic [1:0]   state1, fill1;

    int n_vec = 0;
    int n_fail = 0;
    int rel_cnt = 0;
    int idle = 0;

    dwc_beat_t   exp_q[$];
    dwc_beat_t   obs_q[$];
    logic [31:0] part[$];
    logic [31:0] exp1_dat[$];
    logic        exp1_lst[$];
    logic [31:0] obs1_q[$];

    always #5 clk = ~clk;

    dwc_cmd_upsizer #(.IN_W(32), .OUT_W(128), .OUT_DEPTH(2), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .state(state), .fill(fill)
    );

    dwc_cmd_upsizer #(.IN_W(32), .OUT_W(32), .OUT_DEPTH(2), .TIMEOUT(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data), .s_last(s1_last),
        .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .m_keep(m1_keep), .m_last(m1_last),
        .state(state1), .fill(fill1)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic dwc_beat_t obs_at(input int k);
        dwc_beat_t b;
        b = '0;
        if (k < obs_q.size()) b = obs_q[k];
        return b;
    endfunction

    function automatic logic [31:0] obs1_at(input int k);
        logic [31:0] w;
        w = '0;
        if (k < obs1_q.size()) w = obs1_q[k];
        return w;
    endfunction

    // A beat is simply the accepted words in arrival order, word 0 lowest, keep one bit per word.
    task automatic close_part(input logic lst);
        dwc_beat_t b;
        b = '0;
        foreach (part[i]) begin
            b.data[i*32 +: 32] = part[i];
            b.keep[i]          = 1'b1;
        end
        b.last = lst;
        exp_q.push_back(b);
        part.delete();
        idle = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rel_cnt <= 0;
        else if (rel_cnt < 2) rel_cnt <= rel_cnt + 1;
    end

    // Compare, then advance the model by the handshakes that the coming edge will perform.
    always @(negedge clk) begin
        dwc_beat_t b;
        if (!rst_n) begin
            exp_q.delete(); part.delete(); idle = 0;
            exp1_dat.delete(); exp1_lst.delete();
        end
        check("m_valid", m_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("m_data", m_data, exp_q[0].data);
            check("m_keep", m_keep, exp_q[0].keep);
            check("m_last", m_last, exp_q[0].last);
        end
        check("s_ready", s_ready, rst_n && rel_cnt >= 1 && exp_q.size() < 2);
        check("fill", fill, exp_q.size());
        check("state", state, (part.size() != 0) ? 2'd1 : 2'd0);

        check("m1_valid", m1_valid, exp1_dat.size() != 0);
        if (exp1_dat.size() != 0) begin
            check("m1_data", m1_data, exp1_dat[0]);
            check("m1_keep", m1_keep, 1'b1);
            check("m1_last", m1_last, exp1_lst[0]);
        end
        check("s1_ready", s1_ready, rst_n && rel_cnt >= 1 && exp1_dat.size() < 2);
        check("fill1", fill1, exp1_dat.size());
        check("state1", state1, 2'd0);

        if (rst_n) begin
            if (m_valid && m_ready) begin
                b.data = m_data; b.keep = m_keep; b.last = m_last;
                obs_q.push_back(b);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                part.push_back(s_data);
                idle = 0;
                if (part.size() == 4 || s_last) close_part(s_last);
            end else if (part.size() != 0) begin
                idle++;
`ifdef DWC_CMD_TIMEOUT_EN
                if (idle == TMO) close_part(1'b0);
`endif
            end

            if (m1_valid && m1_ready) begin
                obs1_q.push_back(m1_data);
                if (exp1_dat.size() != 0) begin
                    void'(exp1_dat.pop_front());
                    void'(exp1_lst.pop_front());
                end
            end
            if (s1_valid && s1_ready) begin
                exp1_dat.push_back(s1_data);
                exp1_lst.push_back(s1_last);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, output int stalls);
        stalls = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        while (!s_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_vec++; n_fail++;
            $display("FAIL send_wait: s_ready got 0 want 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d, input logic l, output int stalls);
        stalls = 0;
        s1_valid = 1'b1; s1_data = d; s1_last = l;
        @(negedge clk);
        while (!s1_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (!s1_ready) begin
            n_vec++; n_fail++;
            $display("FAIL send1_wait: s1_ready got 0 want 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        s1_valid = 1'b0; s1_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no completion, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, tot;
        logic [127:0] held;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_keep", m_keep, 0);
        check("rst_m_last", m_last, 0);
        check("rst_state", state, 0);
        check("rst_fill", fill, 0);
        check("rst_s_ready", s_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_first_cycle", s_ready, 0);
        @(negedge clk);
        check("s_ready_open", s_ready, 1);
        @(posedge clk); #1;

        // Streaming 0x11..0x88
        obs_q.delete();
        tot = 0;
        for (int i = 1; i <= 8; i++) begin
            send(32'(i * 32'h11), 1'b0, st);
            tot += st;
        end
        check("stream_stalls", tot, 0);
        cycles(3);
        check("stream_beats", obs_q.size(), 2);
        check("stream_b0_data", obs_at(0).data, 128'h00000044_00000033_00000022_00000011);
        check("stream_b0_keep", obs_at(0).keep, 4'hF);
        check("stream_b0_last", obs_at(0).last, 1'b0);
        check("stream_b1_data", obs_at(1).data, 128'h00000088_00000077_00000066_00000055);

        // Early last
        obs_q.delete();
        send(32'hA, 1'b0, st);
        send(32'hB, 1'b1, st);
        check("early_valid_next", m_valid, 1);
        check("early_keep_next", m_keep, 4'h3);
        cycles(2);
        check("early_beats", obs_q.size(), 1);
        check("early_data", obs_at(0).data, 128'h00000000_00000000_0000000B_0000000A);
        check("early_keep", obs_at(0).keep, 4'h3);
        check("early_last", obs_at(0).last, 1'b1);

        // Backpressure: 12 words with the sink stalled, then released
        obs_q.delete();
        m_ready = 1'b0;
        fork
            for (int i = 1; i <= 12; i++) send(32'(32'h100 + i), 1'b0, st);
            begin
                cycles(15);
                @(negedge clk);
                check("bp_fill", fill, 2);
                check("bp_s_ready", s_ready, 0);
                held = m_data;
                check("bp_head", held, 128'h00000104_00000103_00000102_00000101);
                repeat (4) @(negedge clk);
                check("bp_stable", m_data, held);
                @(posedge clk); #1 m_ready = 1'b1;
            end
        join
        cycles(4);
        check("bp_beats", obs_q.size(), 3);
        check("bp_b0", obs_at(0).data, 128'h00000104_00000103_00000102_00000101);
        check("bp_b1", obs_at(1).data, 128'h00000108_00000107_00000106_00000105);
        check("bp_b2", obs_at(2).data, 128'h0000010C_0000010B_0000010A_00000109);

        // RATIO == 1 instance
        obs1_q.delete();
        send1(32'hDEADBEEF, 1'b0, st);
        check("r1_valid_next", m1_valid, 1);
        check("r1_data_next", m1_data, 32'hDEADBEEF);
        check("r1_keep_next", m1_keep, 1'b1);
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send1(32'(32'hC0 + i), (i == 3), st);
            tot += st;
        end
        check("r1_stalls", tot, 0);
        cycles(2);
        check("r1_beats", obs1_q.size(), 5);
        check("r1_b4", obs1_at(4), 32'hC3);

        // Idle flush
        obs_q.delete();
        send(32'h5, 1'b0, st);
`ifdef DWC_CMD_TIMEOUT_EN
        cycles(3);
        check("tmo_not_yet", m_valid, 0);
        cycles(1);
        check("tmo_valid", m_valid, 1);
        cycles(4);
        check("tmo_beats", obs_q.size(), 1);
        check("tmo_data", obs_at(0).data, 128'h5);
        check("tmo_keep", obs_at(0).keep, 4'h1);
        check("tmo_last", obs_at(0).last, 1'b0);
`else
        cycles(8);
        check("no_tmo_beats", obs_q.size(), 0);
        check("no_tmo_state", state, 2'd1);
`endif

        // Reset in the middle of a partial beat
        obs_q.delete();
        send(32'h21, 1'b0, st);
        send(32'h22, 1'b0, st);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_fill", fill, 0);
        check("mid_rst_state", state, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycles(2);
        for (int i = 1; i <= 4; i++) send(32'(32'h30 + i), 1'b0, st);
        cycles(2);
        check("mid_rst_beats", obs_q.size(), 1);
        check("mid_rst_data", obs_at(0).data, 128'h00000034_00000033_00000032_00000031);
        check("mid_rst_keep", obs_at(0).keep, 4'hF);
        check("mid_rst_last", obs_at(0).last, 1'b0);

        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
